pc_ras: RTL and testbench
=========================

Name: pc_ras

Overview:
- Parametrised next-generation program counter for the TiniSOC fetch stage.
- Retains next-PC selection: sequential, conditional branch (BEQ/BNE), J/JAL, and JR.
- Generalises PC width and instruction step, and uses full-width sign-extended branch and jump offsets.
- Adds a return-address stack (RAS) that predicts JR targets, plus a saturating mispredict counter and sticky stack-error flags.

Parameters:
- PC_WIDTH, 10, width of current_pc and all target arithmetic.
- RAS_DEPTH, 4, number of RAS entries (power of 2, at least 2).
- RESET_PC, 0, value loaded into current_pc on reset.
- INSTR_BYTES, 4, sequential increment.
- CNT_WIDTH, 8, width of the mispredict counter.

Ports:
- clock  in  1  system clock; all state updates on negedge clock.
- reset  in  1  synchronous, active-high reset.
- enable_pc  in  1  allows a PC/RAS update this cycle.
- do_hazard  in  1  freezes PC and RAS; has priority over enable_pc.
- opcode  in  6  decode-stage opcode.
- sub_op_b  in  1  BEQ/BNE select.
- sub_op_j  in  1  JJ/JAL select.
- reg_rt_ra_equal  in  1  branch compare result.
- imm_14bit  in  14  branch halfword offset.
- imm_24bit  in  24  jump halfword offset.
- reg_rb_data  in  32  JR register value; low PC_WIDTH bits are used.
- current_pc  out  PC_WIDTH  fetch address.
- do_jump_link  out  1  JAL in decode (combinational).
- link_pc  out  PC_WIDTH  link value, equal to current_pc (combinational).
- do_flush_REG1  out  1  redirect taken; flush IF/ID (combinational).
- ras_predict_pc  out  PC_WIDTH  RAS top-of-stack; 0 when empty.
- ras_empty  out  1  stack empty.
- ras_full  out  1  stack full.
- ras_overflow  out  1  sticky: a push occurred while full.
- ras_underflow  out  1  sticky: a JR occurred while empty.
- mispredict_cnt  out  CNT_WIDTH  saturating count of RAS mispredicts.

Behaviour:
- Reset, synchronous on negedge clock with reset=1:
  - current_pc=RESET_PC.
  - RAS pointer and count cleared; ras_empty=1, ras_full=0.
  - ras_overflow=0, ras_underflow=0, mispredict_cnt=0.
  - Reset overrides hazard and enable, and aborts any in-progress push or pop.
- Update enable: upd = !reset && !do_hazard && enable_pc. With upd=0, all state holds.
- Selection (combinational, same encodings as the def_muxs PC_* codes):
  - TY_B: PC_14BIT if (BEQ && equal) or (BNE && !equal); otherwise PC_4.
  - TY_J: PC_24BIT; do_jump_link=1 only when sub_op_j==JAL.
  - JR: PC_REGISTER.
  - Any other opcode: PC_4.
- Targets, computed modulo 2^PC_WIDTH (wrap-around allowed, no error):
  - PC_4: current_pc+INSTR_BYTES.
  - PC_14BIT: (current_pc-INSTR_BYTES) + sext({imm_14bit,1'b0}).
  - PC_24BIT: (current_pc-INSTR_BYTES) + sext({imm_24bit,1'b0}).
  - PC_REGISTER: reg_rb_data[PC_WIDTH-1:0].
  - Sign extension goes to max(PC_WIDTH, imm+1) bits, then truncates to PC_WIDTH.
- do_flush_REG1=1 for any non-PC_4 selection. It is combinational and independent of enable and hazard, so the pipeline gates it.
- RAS push:
  - Occurs on upd && JAL; pushes link_pc (current_pc).
  - When full: overwrite the oldest entry (circular buffer), count stays RAS_DEPTH, set ras_overflow.
- RAS pop:
  - Occurs on upd && JR && !ras_empty.
  - If ras_predict_pc != reg_rb_data[PC_WIDTH-1:0], mispredict_cnt increments, saturating at all-ones.
  - JR with an empty stack: no pop, no count change, set ras_underflow.
  - The actual JR target is always reg_rb_data; the RAS is advisory only.
- Push and pop are mutually exclusive by opcode; no simultaneous case.
- Latency:
  - current_pc changes at the negedge following upd.
  - RAS flags and the counter update at the same edge.
  - ras_predict_pc reflects the new top immediately after that edge.
- Held hazard across a JAL or JR: no push or pop until the hazard releases; then exactly one update.

Decomposition:
- Opcode and sub-op constants (TY_B, TY_J, JR, BEQ, BNE, JJ, JAL) stay in def_opcode.v.
- PC_4/PC_14BIT/PC_24BIT/PC_REGISTER stay in def_muxs.v.
- Add RAS_OP_NONE/PUSH/POP to def_muxs.v.
- Natural sub-module: ras_stack.
  - Parameters: DEPTH, WIDTH.
  - Ports: clock, reset, push, pop, push_data, top, empty, full, overflow, underflow.
  - Implements the circular overwrite and pointer logic.
- pc_ras keeps selection, target arithmetic, PC register and mispredict counter.

Test Plan:
- Reset then 3 cycles of opcode=ALU with enable_pc=1 -> current_pc 0→4→8→12; do_flush_REG1=0.
- current_pc=20, TY_B BEQ, equal=1, imm_14bit=14'h3FFC (−4 halfwords) -> next current_pc=8; do_flush_REG1=1. Repeat with equal=0 -> 24.
- PC_WIDTH=10, current_pc=1020, ALU -> wraps to 0. Then TY_J JAL, imm_24bit=2 -> do_jump_link=1, link_pc=0, target 0 (=0−4+4), RAS holds 0.
- RAS_DEPTH=4, five JALs at pc 100/200/300/400/500 -> ras_full=1, ras_overflow=1, top=500. Four JRs with matching reg_rb_data -> cnt=0, then ras_empty=1. Fifth JR -> ras_underflow=1, current_pc=reg_rb_data.
- JR with RAS top=200, reg_rb_data=204 -> mispredict_cnt=1, current_pc=204. Force 300 mispredicts with CNT_WIDTH=8 -> counter saturates at 255.
- JAL held with do_hazard=1 for 3 cycles -> PC and RAS unchanged; release -> exactly one push. Assert reset mid-sequence -> all outputs return to reset values at the next negedge.

Source files
------------

// File: rtl/pc_ras_pkg.sv
// rtl/pc_ras_pkg.sv - opcode, sub-op, PC-select and RAS-op encodings for pc_ras
package pc_ras_pkg;

  localparam logic [5:0] OP_ALU = 6'h00;
  localparam logic [5:0] TY_J   = 6'h02;
  localparam logic [5:0] TY_B   = 6'h04;
  localparam logic [5:0] JR     = 6'h08;

  localparam logic BEQ = 1'b0;
  localparam logic BNE = 1'b1;
  localparam logic JJ  = 1'b0;
  localparam logic JAL = 1'b1;

  typedef enum logic [1:0] {
    PC_4        = 2'd0,
    PC_14BIT    = 2'd1,
    PC_24BIT    = 2'd2,
    PC_REGISTER = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    RAS_OP_NONE = 2'd0,
    RAS_OP_PUSH = 2'd1,
    RAS_OP_POP  = 2'd2
  } ras_op_e;

endpackage

// File: rtl/pc_ras_ras_stack.sv
// rtl/pc_ras_ras_stack.sv - circular return-address stack with sticky overflow/underflow
// A push while full overwrites the oldest entry, which is the slot the write pointer has wrapped onto.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    count;
  logic [PW-1:0]    top_idx;

  assign top_idx = ptr - PW'(1);
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign top     = empty ? '0 : mem[top_idx];

  always_ff @(negedge clock) begin
    if (reset) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + PW'(1);
      if (full) overflow <= 1'b1;
      else      count    <= count + CW'(1);
    end else if (pop) begin
      if (empty) begin
        underflow <= 1'b1;
      end else begin
        ptr   <= top_idx;
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - fetch-stage program counter with return-address prediction for JR
// The RAS is advisory: JR always redirects to reg_rb_data; the stack only feeds the mispredict counter.
module pc_ras
  import pc_ras_pkg::*;
#(
  parameter int                PC_WIDTH    = 10,
  parameter int                RAS_DEPTH   = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                INSTR_BYTES = 4,
  parameter int                CNT_WIDTH   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable_pc,
  input  logic                 do_hazard,
  input  logic [5:0]           opcode,
  input  logic                 sub_op_b,
  input  logic                 sub_op_j,
  input  logic                 reg_rt_ra_equal,
  input  logic [13:0]          imm_14bit,
  input  logic [23:0]          imm_24bit,
  input  logic [31:0]          reg_rb_data,
  output logic [PC_WIDTH-1:0]  current_pc,
  output logic                 do_jump_link,
  output logic [PC_WIDTH-1:0]  link_pc,
  output logic                 do_flush_REG1,
  output logic [PC_WIDTH-1:0]  ras_predict_pc,
  output logic                 ras_empty,
  output logic                 ras_full,
  output logic                 ras_overflow,
  output logic                 ras_underflow,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);

  pc_sel_e             pc_sel;
  ras_op_e             ras_op;
  logic                upd;
  logic                mispredict;
  logic [PC_WIDTH-1:0] base_pc;
  logic [PC_WIDTH-1:0] rb_pc;
  logic [PC_WIDTH-1:0] next_pc;
  logic signed [14:0]  off14;
  logic signed [24:0]  off24;
  logic                unused_rb;

  assign upd          = !reset && !do_hazard && enable_pc;
  assign link_pc      = current_pc;
  assign do_jump_link = (opcode == TY_J) && (sub_op_j == JAL);
  assign rb_pc        = reg_rb_data[PC_WIDTH-1:0];
  assign unused_rb    = ^reg_rb_data[31:PC_WIDTH];
  // Offsets are in halfwords; the target is relative to the branch itself, one step behind current_pc.
  assign base_pc      = current_pc - PC_WIDTH'(INSTR_BYTES);
  assign off14        = {imm_14bit, 1'b0};
  assign off24        = {imm_24bit, 1'b0};

  always_comb begin
    pc_sel = PC_4;
    ras_op = RAS_OP_NONE;
    case (opcode)
      TY_B: begin
        if (((sub_op_b == BEQ) && reg_rt_ra_equal) || ((sub_op_b == BNE) && !reg_rt_ra_equal))
          pc_sel = PC_14BIT;
      end
      TY_J: begin
        pc_sel = PC_24BIT;
        if (sub_op_j == JAL) ras_op = RAS_OP_PUSH;
      end
      JR: begin
        pc_sel = PC_REGISTER;
        ras_op = RAS_OP_POP;
      end
      default: ;
    endcase
  end

  always_comb begin
    next_pc = current_pc + PC_WIDTH'(INSTR_BYTES);
    case (pc_sel)
      PC_14BIT:    next_pc = base_pc + PC_WIDTH'(off14);
      PC_24BIT:    next_pc = base_pc + PC_WIDTH'(off24);
      PC_REGISTER: next_pc = rb_pc;
      default:     ;
    endcase
  end

  assign do_flush_REG1 = (pc_sel != PC_4);
  assign mispredict    = upd && (ras_op == RAS_OP_POP) && !ras_empty && (ras_predict_pc != rb_pc);

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (upd && (ras_op == RAS_OP_PUSH)),
    .pop       (upd && (ras_op == RAS_OP_POP)),
    .push_data (link_pc),
    .top       (ras_predict_pc),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  always_ff @(negedge clock) begin
    if (reset) begin
      current_pc     <= RESET_PC;
      mispredict_cnt <= '0;
    end else begin
      if (upd) current_pc <= next_pc;
      if (mispredict && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pc_ras.sv
// tb/tb_pc_ras.sv - directed self-checking bench for pc_ras
module tb_pc_ras;
  import pc_ras_pkg::*;

  logic        clock = 1'b0;
  logic        reset, enable_pc, do_hazard;
  logic [5:0]  opcode;
  logic        sub_op_b, sub_op_j, reg_rt_ra_equal;
  logic [13:0] imm_14bit;
  logic [23:0] imm_24bit;
  logic [31:0] reg_rb_data;
  logic [9:0]  current_pc, link_pc, ras_predict_pc;
  logic        do_jump_link, do_flush_REG1, ras_empty, ras_full, ras_overflow, ras_underflow;
  logic [7:0]  mispredict_cnt;

  int checks = 0;
  int errors = 0;

  pc_ras #(
    .PC_WIDTH(10), .RAS_DEPTH(4), .RESET_PC(10'd0), .INSTR_BYTES(4), .CNT_WIDTH(8)
  ) dut (
    .clock(clock), .reset(reset), .enable_pc(enable_pc), .do_hazard(do_hazard),
    .opcode(opcode), .sub_op_b(sub_op_b), .sub_op_j(sub_op_j),
    .reg_rt_ra_equal(reg_rt_ra_equal), .imm_14bit(imm_14bit), .imm_24bit(imm_24bit),
    .reg_rb_data(reg_rb_data), .current_pc(current_pc), .do_jump_link(do_jump_link),
    .link_pc(link_pc), .do_flush_REG1(do_flush_REG1), .ras_predict_pc(ras_predict_pc),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clock = ~clock;

  task automatic set_in(input logic [5:0] op, input logic b, input logic j, input logic eq,
                        input logic [13:0] i14, input logic [23:0] i24, input logic [31:0] rb);
    opcode = op; sub_op_b = b; sub_op_j = j; reg_rt_ra_equal = eq;
    imm_14bit = i14; imm_24bit = i24; reg_rb_data = rb;
    #1;
  endtask

  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    set_in(OP_ALU, 0, 0, 0, 14'd0, 24'd0, 32'd0);
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable_pc = 1'b1; do_hazard = 1'b0;
    set_in(OP_ALU, 0, 0, 0, 14'd0, 24'd0, 32'd0);
    tick; tick;
    checks++; if (current_pc !== 10'd0) begin errors++; $display("FAIL reset_pc got %0d exp 0", current_pc); end
    checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++; $display("FAIL reset_ras got empty=%b full=%b exp 1 0", ras_empty, ras_full); end
    checks++; if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin errors++; $display("FAIL reset_flags got ov=%b un=%b exp 0 0", ras_overflow, ras_underflow); end
    checks++; if (mispredict_cnt !== 8'd0 || ras_predict_pc !== 10'd0) begin errors++; $display("FAIL reset_cnt got cnt=%0d top=%0d exp 0 0", mispredict_cnt, ras_predict_pc); end
    reset = 1'b0;
  endtask

  task automatic test_sequential;
    for (int i = 1; i <= 3; i++) begin
      set_in(OP_ALU, 0, 0, 0, 14'd0, 24'd0, 32'd0);
      checks++; if (do_flush_REG1 !== 1'b0) begin errors++; $display("FAIL seq_flush got %b exp 0", do_flush_REG1); end
      tick;
      checks++; if (current_pc !== 10'(4 * i)) begin errors++; $display("FAIL seq_pc got %0d exp %0d", current_pc, 4 * i); end
    end
    tick; tick;
    checks++; if (current_pc !== 10'd20) begin errors++; $display("FAIL seq_pc20 got %0d exp 20", current_pc); end
  endtask

  task automatic test_branch;
    set_in(TY_B, BEQ, 0, 1, 14'h3FFC, 24'd0, 32'd0);
    checks++; if (do_flush_REG1 !== 1'b1) begin errors++; $display("FAIL beq_taken_flush got %b exp 1", do_flush_REG1); end
    tick;
    checks++; if (current_pc !== 10'd8) begin errors++; $display("FAIL beq_taken_pc got %0d exp 8", current_pc); end
    set_in(TY_J, 0, JJ, 0, 14'd0, 24'd8, 32'd0);
    checks++; if (do_jump_link !== 1'b0 || do_flush_REG1 !== 1'b1) begin errors++; $display("FAIL jj_comb got link=%b flush=%b exp 0 1", do_jump_link, do_flush_REG1); end
    tick;
    checks++; if (current_pc !== 10'd20 || ras_empty !== 1'b1) begin errors++; $display("FAIL jj_pc got %0d empty=%b exp 20 1", current_pc, ras_empty); end
    set_in(TY_B, BEQ, 0, 0, 14'h3FFC, 24'd0, 32'd0);
    checks++; if (do_flush_REG1 !== 1'b0) begin errors++; $display("FAIL beq_nt_flush got %b exp 0", do_flush_REG1); end
    tick;
    checks++; if (current_pc !== 10'd24) begin errors++; $display("FAIL beq_nt_pc got %0d exp 24", current_pc); end
    set_in(TY_B, BNE, 0, 0, 14'h3FFC, 24'd0, 32'd0);
    checks++; if (do_flush_REG1 !== 1'b1) begin errors++; $display("FAIL bne_taken_flush got %b exp 1", do_flush_REG1); end
    tick;
    checks++; if (current_pc !== 10'd12) begin errors++; $display("FAIL bne_taken_pc got %0d exp 12", current_pc); end
    set_in(TY_B, BNE, 0, 1, 14'h3FFC, 24'd0, 32'd0);
    tick;
    checks++; if (current_pc !== 10'd16) begin errors++; $display("FAIL bne_nt_pc got %0d exp 16", current_pc); end
  endtask

  task automatic test_wrap;
    set_in(TY_J, 0, JJ, 0, 14'd0, 24'd504, 32'd0);
    tick;
    checks++; if (current_pc !== 10'd1020) begin errors++; $display("FAIL wrap_jump got %0d exp 1020", current_pc); end
    set_in(OP_ALU, 0, 0, 0, 14'd0, 24'd0, 32'd0);
    tick;
    checks++; if (current_pc !== 10'd0) begin errors++; $display("FAIL wrap_seq got %0d exp 0", current_pc); end
    set_in(TY_J, 0, JAL, 0, 14'd0, 24'd2, 32'd0);
    checks++; if (do_jump_link !== 1'b1 || link_pc !== 10'd0 || do_flush_REG1 !== 1'b1) begin errors++; $display("FAIL jal_comb got link=%b lpc=%0d flush=%b exp 1 0 1", do_jump_link, link_pc, do_flush_REG1); end
    tick;
    checks++; if (current_pc !== 10'd0 || ras_empty !== 1'b0 || ras_predict_pc !== 10'd0) begin errors++; $display("FAIL jal_wrap got pc=%0d empty=%b top=%0d exp 0 0 0", current_pc, ras_empty, ras_predict_pc); end
  endtask

  task automatic test_ras_overflow;
    logic [31:0] rb;
    do_reset;
    set_in(TY_J, 0, JJ, 0, 14'd0, 24'd52, 32'd0);
    tick;
    for (int k = 1; k <= 5; k++) begin
      set_in(TY_J, 0, JAL, 0, 14'd0, 24'd52, 32'd0);
      tick;
      checks++;
      if (current_pc !== 10'(100 * (k + 1)) || ras_predict_pc !== 10'(100 * k) ||
          ras_full !== (k >= 4) || ras_overflow !== (k == 5)) begin
        errors++;
        $display("FAIL push_%0d got pc=%0d top=%0d full=%b ov=%b exp %0d %0d %b %b", k, current_pc,
                 ras_predict_pc, ras_full, ras_overflow, 100 * (k + 1), 100 * k, k >= 4, k == 5);
      end
    end
    for (int k = 0; k < 4; k++) begin
      rb = 32'(500 - 100 * k);
      set_in(JR, 0, 0, 0, 14'd0, 24'd0, rb);
      tick;
      checks++;
      if (current_pc !== rb[9:0] || mispredict_cnt !== 8'd0 || ras_empty !== (k == 3) ||
          ras_predict_pc !== ((k == 3) ? 10'd0 : 10'(400 - 100 * k))) begin
        errors++;
        $display("FAIL pop_%0d got pc=%0d cnt=%0d empty=%b top=%0d exp %0d 0 %b %0d", k, current_pc,
                 mispredict_cnt, ras_empty, ras_predict_pc, rb, k == 3, (k == 3) ? 0 : 400 - 100 * k);
      end
    end
    set_in(JR, 0, 0, 0, 14'd0, 24'd0, 32'hFFFF_F123);
    tick;
    checks++; if (ras_underflow !== 1'b1 || current_pc !== 10'h123 || mispredict_cnt !== 8'd0 || ras_empty !== 1'b1) begin
      errors++; $display("FAIL underflow got un=%b pc=%0h cnt=%0d empty=%b exp 1 123 0 1", ras_underflow, current_pc, mispredict_cnt, ras_empty);
    end
  endtask

  task automatic test_mispredict;
    int p;
    do_reset;
    set_in(TY_J, 0, JJ, 0, 14'd0, 24'd102, 32'd0);
    tick;
    set_in(TY_J, 0, JAL, 0, 14'd0, 24'd2, 32'd0);
    tick;
    checks++; if (current_pc !== 10'd200 || ras_predict_pc !== 10'd200) begin errors++; $display("FAIL mp_push got pc=%0d top=%0d exp 200 200", current_pc, ras_predict_pc); end
    set_in(JR, 0, 0, 0, 14'd0, 24'd0, 32'd204);
    tick;
    checks++; if (mispredict_cnt !== 8'd1 || current_pc !== 10'd204 || ras_empty !== 1'b1) begin errors++; $display("FAIL mp_one got cnt=%0d pc=%0d empty=%b exp 1 204 1", mispredict_cnt, current_pc, ras_empty); end
    p = 204;
    for (int i = 0; i < 300; i++) begin
      set_in(TY_J, 0, JAL, 0, 14'd0, 24'd2, 32'd0);
      tick;
      set_in(JR, 0, 0, 0, 14'd0, 24'd0, 32'(p + 8));
      tick;
      p = (p + 8) % 1024;
      if (i == 252) begin
        checks++; if (mispredict_cnt !== 8'd254 || current_pc !== 10'(p)) begin errors++; $display("FAIL mp_254 got cnt=%0d pc=%0d exp 254 %0d", mispredict_cnt, current_pc, p); end
      end
    end
    checks++; if (mispredict_cnt !== 8'd255) begin errors++; $display("FAIL mp_saturate got %0d exp 255", mispredict_cnt); end
  endtask

  task automatic test_hazard;
    do_reset;
    set_in(OP_ALU, 0, 0, 0, 14'd0, 24'd0, 32'd0);
    tick;
    do_hazard = 1'b1;
    set_in(TY_J, 0, JAL, 0, 14'd0, 24'd4, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (current_pc !== 10'd4 || ras_empty !== 1'b1) begin errors++; $display("FAIL hazard_hold got pc=%0d empty=%b exp 4 1", current_pc, ras_empty); end
    end
    do_hazard = 1'b0;
    tick;
    checks++; if (current_pc !== 10'd8 || ras_predict_pc !== 10'd4 || ras_empty !== 1'b0) begin errors++; $display("FAIL hazard_release got pc=%0d top=%0d empty=%b exp 8 4 0", current_pc, ras_predict_pc, ras_empty); end
    enable_pc = 1'b0;
    set_in(JR, 0, 0, 0, 14'd0, 24'd0, 32'd4);
    tick;
    checks++; if (current_pc !== 10'd8 || ras_empty !== 1'b0) begin errors++; $display("FAIL enable_hold got pc=%0d empty=%b exp 8 0", current_pc, ras_empty); end
    enable_pc = 1'b1;
    tick;
    checks++; if (current_pc !== 10'd4 || ras_empty !== 1'b1 || mispredict_cnt !== 8'd0) begin errors++; $display("FAIL single_push got pc=%0d empty=%b cnt=%0d exp 4 1 0", current_pc, ras_empty, mispredict_cnt); end
  endtask

  task automatic test_reset_mid;
    set_in(JR, 0, 0, 0, 14'd0, 24'd0, 32'd40);
    tick;
    set_in(TY_J, 0, JAL, 0, 14'd0, 24'd2, 32'd0);
    tick; tick;
    set_in(JR, 0, 0, 0, 14'd0, 24'd0, 32'd44);
    tick;
    checks++; if (ras_underflow !== 1'b1 || mispredict_cnt !== 8'd1 || ras_empty !== 1'b0 || current_pc !== 10'd44) begin
      errors++; $display("FAIL mid_setup got un=%b cnt=%0d empty=%b pc=%0d exp 1 1 0 44", ras_underflow, mispredict_cnt, ras_empty, current_pc);
    end
    reset = 1'b1; do_hazard = 1'b1;
    set_in(TY_J, 0, JAL, 0, 14'd0, 24'd2, 32'd0);
    tick;
    checks++; if (current_pc !== 10'd0 || ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_predict_pc !== 10'd0) begin
      errors++; $display("FAIL mid_reset_ras got pc=%0d empty=%b full=%b top=%0d exp 0 1 0 0", current_pc, ras_empty, ras_full, ras_predict_pc);
    end
    checks++; if (ras_underflow !== 1'b0 || ras_overflow !== 1'b0 || mispredict_cnt !== 8'd0) begin
      errors++; $display("FAIL mid_reset_flags got un=%b ov=%b cnt=%0d exp 0 0 0", ras_underflow, ras_overflow, mispredict_cnt);
    end
    reset = 1'b0; do_hazard = 1'b0;
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_branch;
    test_wrap;
    test_ras_overflow;
    test_mispredict;
    test_hazard;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
